// File: rtl/mem_bus_responder_pkg.sv
// Shared encodings for the memory responder: FSM states, funct3 access codes and
// the request legality rule used at accept time.
package mem_bus_responder_pkg;

  typedef enum logic [2:0] {
    ST_MEM_IDLE  = 3'd0,
    ST_MEM_RD    = 3'd1,
    ST_MEM_WAIT  = 3'd2,
    ST_MEM_MERGE = 3'd3,
    ST_MEM_WR    = 3'd4,
    ST_MEM_DONE  = 3'd5,
    ST_MEM_ERR   = 3'd6
  } mem_state_e;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  // Loads and stores share funct3 codes, so legality depends on the direction.
  function automatic logic req_illegal(input logic       rd,
                                       input logic       wr,
                                       input logic [1:0] lane,
                                       input logic [2:0] f3);
    logic bad;
    bad = 1'b0;
    if (rd && wr) begin
      bad = 1'b1;
    end else if (wr) begin
      case (f3)
        FUNCT3_SB: bad = 1'b0;
        FUNCT3_SH: bad = lane[0];
        FUNCT3_SW: bad = |lane;
        default:   bad = 1'b1;
      endcase
    end else begin
      case (f3)
        FUNCT3_LB, FUNCT3_LBU: bad = 1'b0;
        FUNCT3_LH, FUNCT3_LHU: bad = lane[0];
        FUNCT3_LW:             bad = |lane;
        default:               bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_bus_responder_lsu_align.sv
// Combinational lane logic: extracts/extends a load from an SRAM word and merges
// store bytes/halves into the previously read word.
module lsu_align
  import mem_bus_responder_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_store,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_lane)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    case (i_funct3)
      FUNCT3_LB:  o_load = {{24{w_byte[7]}}, w_byte};
      FUNCT3_LBU: o_load = {24'd0, w_byte};
      FUNCT3_LH:  o_load = {{16{w_half[15]}}, w_half};
      FUNCT3_LHU: o_load = {16'd0, w_half};
      default:    o_load = i_word;
    endcase
  end

  always_comb begin
    o_merged = i_store;
    if (i_funct3 == FUNCT3_SB) begin
      o_merged = i_word;
      case (i_lane)
        2'd0:    o_merged[7:0]   = i_store[7:0];
        2'd1:    o_merged[15:8]  = i_store[7:0];
        2'd2:    o_merged[23:16] = i_store[7:0];
        default: o_merged[31:24] = i_store[7:0];
      endcase
    end else if (i_funct3 == FUNCT3_SH) begin
      o_merged = i_word;
      if (i_lane[1]) o_merged[31:16] = i_store[15:0];
      else           o_merged[15:0]  = i_store[15:0];
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder: one load/store per request against a word-wide synchronous
// SRAM with LATENCY read wait-states; SB/SH are done as read-modify-write.
//   state | meaning
//   IDLE  | waiting for iMemRead/iMemWrite
//   RD    | SRAM read strobe, wait counter loaded
//   WAIT  | LATENCY cycles, read word captured on the last one
//   MERGE | load extract/extend, or store byte/half merge
//   WR    | SRAM write strobe
//   DONE  | oReady pulse (with oError for an illegal request)
//   ERR   | illegal request, no SRAM access
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 1
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iMemRead,
  input  logic              iMemWrite,
  input  logic [31:0]       iAddress,
  input  logic [31:0]       iWriteData,
  input  logic [2:0]        iFunct3,
  output logic [31:0]       oReadData,
  output logic              oReady,
  output logic              oError,
  output logic              oBusy,
  output logic [ADDR_W-1:0] oSramAddr,
  output logic [31:0]       oSramWData,
  output logic              oSramWE,
  output logic              oSramRE,
  input  logic [31:0]       iSramRData,
  output logic [2:0]        oState
);

  localparam logic [3:0] LP_WAIT_LOAD = 4'(LATENCY - 1);

  mem_state_e        r_state, w_next;
  logic              w_req, w_illegal, w_to_wr, w_unused;
  logic [3:0]        r_cnt;
  logic [1:0]        r_lane;
  logic [2:0]        r_funct3;
  logic              r_is_write, r_err;
  logic [31:0]       r_store, r_word, r_read_data, r_sram_wdata;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [31:0]       w_load, w_merged;

  assign w_req     = iMemRead | iMemWrite;
  assign w_illegal = req_illegal(iMemRead, iMemWrite, iAddress[1:0], iFunct3);
  assign w_to_wr   = iMemWrite & (iFunct3 == FUNCT3_SW);
  assign w_unused  = ^iAddress[31:ADDR_W+2];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_state <= ST_MEM_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    oReady  = 1'b0;
    oError  = 1'b0;
    oSramWE = 1'b0;
    oSramRE = 1'b0;
    case (r_state)
      ST_MEM_IDLE: begin
        if (w_req) begin
          if (w_illegal)    w_next = ST_MEM_ERR;
          else if (w_to_wr) w_next = ST_MEM_WR;
          else              w_next = ST_MEM_RD;
        end
      end
      ST_MEM_RD: begin
        oSramRE = 1'b1;
        w_next  = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (r_cnt == 4'd0) w_next = ST_MEM_MERGE;
      end
      ST_MEM_MERGE: begin
        w_next = r_is_write ? ST_MEM_WR : ST_MEM_DONE;
      end
      ST_MEM_WR: begin
        oSramWE = 1'b1;
        w_next  = ST_MEM_DONE;
      end
      ST_MEM_DONE: begin
        oReady = 1'b1;
        oError = r_err;
        w_next = ST_MEM_IDLE;
      end
      ST_MEM_ERR: begin
        w_next = ST_MEM_DONE;
      end
      default: w_next = ST_MEM_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_cnt        <= 4'd0;
      r_lane       <= 2'd0;
      r_funct3     <= 3'd0;
      r_is_write   <= 1'b0;
      r_err        <= 1'b0;
      r_store      <= 32'd0;
      r_word       <= 32'd0;
      r_read_data  <= 32'd0;
      r_sram_wdata <= 32'd0;
      r_sram_addr  <= '0;
    end else begin
      if (r_state == ST_MEM_IDLE && w_req) begin
        r_lane      <= iAddress[1:0];
        r_funct3    <= iFunct3;
        r_is_write  <= iMemWrite;
        r_err       <= w_illegal;
        r_store     <= iWriteData;
        r_sram_addr <= iAddress[ADDR_W+1:2];
        // SW skips the read/merge path, so its word is staged right away.
        if (w_to_wr && !w_illegal) r_sram_wdata <= iWriteData;
      end
      if (r_state == ST_MEM_RD) r_cnt <= LP_WAIT_LOAD;
      if (r_state == ST_MEM_WAIT) begin
        if (r_cnt == 4'd0) r_word <= iSramRData;
        else               r_cnt  <= r_cnt - 4'd1;
      end
      if (r_state == ST_MEM_MERGE) begin
        if (r_is_write) r_sram_wdata <= w_merged;
        else            r_read_data  <= w_load;
      end
    end
  end

  lsu_align u_align (
    .i_word   (r_word),
    .i_store  (r_store),
    .i_lane   (r_lane),
    .i_funct3 (r_funct3),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  assign oBusy      = (r_state != ST_MEM_IDLE);
  assign oReadData  = r_read_data;
  assign oSramAddr  = r_sram_addr;
  assign oSramWData = r_sram_wdata;
  assign oState     = r_state;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: two instances (LATENCY 1 and 3), each with
// its own SRAM model; expectations come from a lane-arithmetic reference model.
`timescale 1ns/1ps
module tb_mem_bus_responder;
  import mem_bus_responder_pkg::*;

  localparam int AW   = 12;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst_n [2] = '{1'b1, 1'b1};
  logic          mem_rd [2], mem_wr [2];
  logic [31:0]   addr [2], wdata [2];
  logic [2:0]    f3 [2];
  logic [31:0]   rdata [2];
  logic          ready [2], err [2], busy [2];
  logic [AW-1:0] s_addr [2];
  logic [31:0]   s_wdata [2], s_rdata [2];
  logic          s_we [2], s_re [2];
  logic [2:0]    state [2];

  mem_bus_responder #(.ADDR_W(AW), .LATENCY(LAT0)) u_l1 (
    .iCLK(clk), .iRST_N(rst_n[0]), .iMemRead(mem_rd[0]), .iMemWrite(mem_wr[0]),
    .iAddress(addr[0]), .iWriteData(wdata[0]), .iFunct3(f3[0]), .oReadData(rdata[0]),
    .oReady(ready[0]), .oError(err[0]), .oBusy(busy[0]), .oSramAddr(s_addr[0]),
    .oSramWData(s_wdata[0]), .oSramWE(s_we[0]), .oSramRE(s_re[0]),
    .iSramRData(s_rdata[0]), .oState(state[0]));

  mem_bus_responder #(.ADDR_W(AW), .LATENCY(LAT1)) u_l3 (
    .iCLK(clk), .iRST_N(rst_n[1]), .iMemRead(mem_rd[1]), .iMemWrite(mem_wr[1]),
    .iAddress(addr[1]), .iWriteData(wdata[1]), .iFunct3(f3[1]), .oReadData(rdata[1]),
    .oReady(ready[1]), .oError(err[1]), .oBusy(busy[1]), .oSramAddr(s_addr[1]),
    .oSramWData(s_wdata[1]), .oSramWE(s_we[1]), .oSramRE(s_re[1]),
    .iSramRData(s_rdata[1]), .oState(state[1]));

  // SRAM models: read data appears LATENCY cycles after the RE cycle, garbage otherwise.
  logic [31:0]   sram [2][4096];
  logic [31:0]   ref_mem [2][4096];
  logic          pv [2][4];
  logic [AW-1:0] pa [2][4];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (s_we[d]) sram[d][s_addr[d]] <= s_wdata[d];
      pv[d][0] <= s_re[d];
      pa[d][0] <= s_addr[d];
      for (int k = 1; k < 4; k++) begin
        pv[d][k] <= pv[d][k-1];
        pa[d][k] <= pa[d][k-1];
      end
    end
  end
  assign s_rdata[0] = pv[0][LAT0-1] ? sram[0][pa[0][LAT0-1]] : 32'hBAD0_BAD0;
  assign s_rdata[1] = pv[1][LAT1-1] ? sram[1][pa[1][LAT1-1]] : 32'hBAD0_BAD0;

  typedef struct {
    bit            err;
    bit            is_load;
    logic [31:0]   data;
    int            rdy;
    int            waits;
    logic [AW-1:0] waddr;
  } exp_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   w;
    int            cyc;
  } acc_t;

  exp_t eq0[$], eq1[$];
  acc_t rq0[$], rq1[$], wq0[$], wq1[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string nm, input int d,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h", nm, d, act, req);
    end
  endtask

  function automatic void model(input bit rd, input bit wr, input logic [31:0] a,
                                input logic [31:0] sd, input logic [2:0] fn,
                                input logic [31:0] word, output bit e,
                                output logic [31:0] ld, output logic [31:0] ww);
    int lane;
    logic [31:0] b, h, m;
    lane = int'(a % 4);
    b  = (word >> (8 * lane)) & 32'hFF;
    h  = (word >> (16 * (lane / 2))) & 32'hFFFF;
    e  = 1'b0;
    ld = 32'd0;
    ww = word;
    if (rd && wr) e = 1'b1;
    else if (rd) begin
      case (fn)
        3'd0: ld = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
        3'd4: ld = b;
        3'd1: begin e = (lane % 2) != 0; ld = (h >= 32768) ? (h | 32'hFFFF_0000) : h; end
        3'd5: begin e = (lane % 2) != 0; ld = h; end
        3'd2: begin e = lane != 0; ld = word; end
        default: e = 1'b1;
      endcase
    end else begin
      case (fn)
        3'd0: begin
          m  = 32'hFF << (8 * lane);
          ww = (word & ~m) | ((sd & 32'hFF) << (8 * lane));
        end
        3'd1: begin
          e  = (lane % 2) != 0;
          m  = 32'hFFFF << (16 * (lane / 2));
          ww = (word & ~m) | ((sd & 32'hFFFF) << (16 * (lane / 2)));
        end
        3'd2: begin e = lane != 0; ww = sd; end
        default: e = 1'b1;
      endcase
    end
  endfunction

  task automatic push_acc(input int d, input bit is_wr, input acc_t x);
    if (is_wr) begin if (d == 0) wq0.push_back(x); else wq1.push_back(x); end
    else       begin if (d == 0) rq0.push_back(x); else rq1.push_back(x); end
  endtask

  // Expectations for the request currently on the inputs of dut d, accepted in cycle c0.
  task automatic push_exp(input int d, input int c0);
    exp_t e;
    acc_t x;
    bit eb;
    logic [31:0] ld, ww;
    logic [AW-1:0] wi;
    int L;
    L  = (d == 0) ? LAT0 : LAT1;
    wi = addr[d][AW+1:2];
    model(mem_rd[d], mem_wr[d], addr[d], wdata[d], f3[d], ref_mem[d][wi], eb, ld, ww);
    e.err = eb; e.is_load = mem_rd[d] && !mem_wr[d]; e.data = ld; e.waddr = wi;
    x.a = wi; x.w = 32'd0; x.cyc = c0 + 1;
    if (eb) begin
      e.rdy = c0 + 2; e.waits = 0;
    end else if (e.is_load) begin
      e.rdy = c0 + 3 + L; e.waits = L;
      push_acc(d, 1'b0, x);
    end else if (f3[d] == 3'd2) begin
      e.rdy = c0 + 2; e.waits = 0;
      x.w = ww;
      push_acc(d, 1'b1, x);
      ref_mem[d][wi] = ww;
    end else begin
      e.rdy = c0 + 4 + L; e.waits = L;
      push_acc(d, 1'b0, x);
      x.w = ww; x.cyc = c0 + 3 + L;
      push_acc(d, 1'b1, x);
      ref_mem[d][wi] = ww;
    end
    if (d == 0) eq0.push_back(e); else eq1.push_back(e);
  endtask

  int waits [2];
  bit p_rdy [2], p_we [2], p_re [2];

  task automatic mon(input int d);
    exp_t e;
    acc_t x;
    bit have;
    if (!rst_n[d]) begin
      waits[d] = 0; p_rdy[d] = 0; p_we[d] = 0; p_re[d] = 0;
      return;
    end
    if (state[d] == ST_MEM_WAIT) waits[d]++;
    if (err[d] && !ready[d]) chk(1'b0, "error_without_ready", d, 32'(err[d]), 32'd0);
    if (ready[d] && p_rdy[d]) chk(1'b0, "ready_two_cycles", d, 32'd1, 32'd0);
    if (s_we[d] && p_we[d])   chk(1'b0, "we_two_cycles", d, 32'd1, 32'd0);
    if (s_re[d] && p_re[d])   chk(1'b0, "re_two_cycles", d, 32'd1, 32'd0);
    if (ready[d]) begin
      have = (d == 0) ? (eq0.size() != 0) : (eq1.size() != 0);
      if (!have) chk(1'b0, "unexpected_ready", d, 32'(cyc), 32'd0);
      else begin
        e = (d == 0) ? eq0.pop_front() : eq1.pop_front();
        chk(cyc == e.rdy, "ready_cycle", d, 32'(cyc), 32'(e.rdy));
        chk(err[d] == e.err, "error_flag", d, 32'(err[d]), 32'(e.err));
        chk(busy[d] == 1'b1, "busy_in_done", d, 32'(busy[d]), 32'd1);
        if (!e.err && e.is_load) chk(rdata[d] == e.data, "load_data", d, rdata[d], e.data);
        if (!e.err) begin
          chk(s_addr[d] == e.waddr, "addr_hold", d, 32'(s_addr[d]), 32'(e.waddr));
          chk(waits[d] == e.waits, "wait_cycles", d, 32'(waits[d]), 32'(e.waits));
        end
      end
      waits[d] = 0;
    end
    if (s_re[d]) begin
      have = (d == 0) ? (rq0.size() != 0) : (rq1.size() != 0);
      if (!have) chk(1'b0, "unexpected_read", d, 32'(s_addr[d]), 32'd0);
      else begin
        x = (d == 0) ? rq0.pop_front() : rq1.pop_front();
        chk(s_addr[d] == x.a, "read_addr", d, 32'(s_addr[d]), 32'(x.a));
        chk(cyc == x.cyc, "read_cycle", d, 32'(cyc), 32'(x.cyc));
      end
    end
    if (s_we[d]) begin
      have = (d == 0) ? (wq0.size() != 0) : (wq1.size() != 0);
      if (!have) chk(1'b0, "unexpected_write", d, 32'(s_addr[d]), 32'd0);
      else begin
        x = (d == 0) ? wq0.pop_front() : wq1.pop_front();
        chk(s_addr[d] == x.a, "write_addr", d, 32'(s_addr[d]), 32'(x.a));
        chk(s_wdata[d] == x.w, "write_data", d, s_wdata[d], x.w);
        chk(cyc == x.cyc, "write_cycle", d, 32'(cyc), 32'(x.cyc));
      end
    end
    p_rdy[d] = ready[d]; p_we[d] = s_we[d]; p_re[d] = s_re[d];
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon(d);
  end

  task automatic chk_zero(input int d);
    chk(ready[d] == 0 && err[d] == 0 && busy[d] == 0, "reset_flags", d,
        {29'd0, ready[d], err[d], busy[d]}, 32'd0);
    chk(s_we[d] == 0 && s_re[d] == 0, "reset_strobes", d, {30'd0, s_we[d], s_re[d]}, 32'd0);
    chk(rdata[d] == 0, "reset_rdata", d, rdata[d], 32'd0);
    chk(s_addr[d] == 0, "reset_sram_addr", d, 32'(s_addr[d]), 32'd0);
    chk(s_wdata[d] == 0, "reset_sram_wdata", d, s_wdata[d], 32'd0);
    chk(state[d] == ST_MEM_IDLE, "reset_state", d, 32'(state[d]), 32'(ST_MEM_IDLE));
  endtask

  task automatic wait_ready(input int d, output int cr);
    bit got;
    int n;
    got = 0; n = 0;
    while (!got && n < 80) begin
      @(posedge clk); #1;
      n++;
      if (ready[d]) got = 1;
    end
    if (!got) chk(1'b0, "ready_timeout", d, 32'(n), 32'd80);
    cr = cyc;
  endtask

  task automatic do_req(input int d, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] sd, input logic [2:0] fn, input bit hold);
    int cr;
    @(posedge clk); #1;
    chk(busy[d] == 1'b0, "idle_before_request", d, 32'(busy[d]), 32'd0);
    mem_rd[d] = rd; mem_wr[d] = wr; addr[d] = a; wdata[d] = sd; f3[d] = fn;
    push_exp(d, cyc);
    wait_ready(d, cr);
    if (hold) begin
      push_exp(d, cr + 1);
      wait_ready(d, cr);
    end
    mem_rd[d] = 1'b0; mem_wr[d] = 1'b0;
  endtask

  task automatic set_word(input int d, input int wi, input logic [31:0] v);
    sram[d][wi] = v;
    ref_mem[d][wi] = v;
  endtask

  task automatic reset_mid_sb(input int d);
    acc_t x;
    bit found;
    int n;
    logic [AW-1:0] wi;
    @(posedge clk); #1;
    mem_wr[d] = 1'b1; addr[d] = 32'h0000_0041; wdata[d] = 32'h0000_005A; f3[d] = FUNCT3_SB;
    wi = addr[d][AW+1:2];
    x.a = wi; x.w = 32'd0; x.cyc = cyc + 1;
    push_acc(d, 1'b0, x);
    found = 0; n = 0;
    while (!found && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (state[d] == ST_MEM_WAIT) found = 1;
    end
    chk(found, "reach_wait", d, 32'(found), 32'd1);
    rst_n[d] = 1'b0;
    mem_wr[d] = 1'b0;
    #1;
    chk_zero(d);
    if (d == 0) begin eq0.delete(); rq0.delete(); wq0.delete(); end
    else        begin eq1.delete(); rq1.delete(); wq1.delete(); end
    repeat (2) @(posedge clk);
    #1 rst_n[d] = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk(sram[d][wi] == ref_mem[d][wi], "no_write_after_reset", d, sram[d][wi], ref_mem[d][wi]);
    do_req(d, 1'b1, 1'b0, 32'h0000_0040, 32'd0, FUNCT3_LW, 1'b0);
  endtask

  initial begin
    logic [31:0] v, a, sd;
    logic [2:0]  fn;
    bit          rd, wr, hold;
    int          d, kind;
    for (int i = 0; i < 2; i++) begin
      mem_rd[i] = 0; mem_wr[i] = 0; addr[i] = 0; wdata[i] = 0; f3[i] = 0;
      rst_n[i] = 1'b0;
      for (int k = 0; k < 4; k++) begin pv[i][k] = 0; pa[i][k] = 0; end
      for (int w = 0; w < 4096; w++) begin
        v = $urandom;
        set_word(i, w, v);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk_zero(0);
    chk_zero(1);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    set_word(0, 4, 32'hDEAD_BEEF);
    do_req(0, 1, 0, 32'h0000_0010, 32'd0, FUNCT3_LW, 0);
    set_word(0, 4, 32'h80FF_0000);
    do_req(0, 1, 0, 32'h0000_0013, 32'd0, FUNCT3_LB, 0);
    do_req(0, 1, 0, 32'h0000_0013, 32'd0, FUNCT3_LBU, 0);
    do_req(0, 1, 0, 32'h0000_0012, 32'd0, FUNCT3_LH, 0);
    do_req(0, 1, 0, 32'h0000_0012, 32'd0, FUNCT3_LHU, 0);
    set_word(0, 8, 32'h1122_3344);
    do_req(0, 0, 1, 32'h0000_0021, 32'h0000_00AB, FUNCT3_SB, 0);
    chk(sram[0][8] == 32'h1122_AB44, "sb_merge_word", 0, sram[0][8], 32'h1122_AB44);
    do_req(0, 0, 1, 32'h0000_0006, 32'h1234_5678, FUNCT3_SW, 0);
    do_req(0, 1, 1, 32'h0000_0010, 32'h1234_5678, FUNCT3_LW, 0);
    do_req(0, 0, 1, 32'h0000_0022, 32'hCAFE_F00D, FUNCT3_SH, 0);
    do_req(0, 0, 1, 32'hFFFF_FFFC, 32'h0BAD_CAFE, FUNCT3_SW, 0);
    do_req(0, 1, 0, 32'h0000_3FFC, 32'd0, FUNCT3_LW, 0);
    do_req(0, 1, 0, 32'h0000_0010, 32'd0, 3'b011, 0);
    do_req(1, 1, 0, 32'h0000_0010, 32'd0, FUNCT3_LW, 0);
    do_req(1, 0, 1, 32'h0000_0023, 32'h0000_0077, FUNCT3_SB, 1);
    do_req(0, 1, 0, 32'h0000_0014, 32'd0, FUNCT3_LH, 1);
    do_req(1, 0, 1, 32'h0000_0008, 32'h5555_AAAA, FUNCT3_SW, 1);

    reset_mid_sb(1);

    for (int n = 0; n < 300; n++) begin
      d = n % 2;
      kind = $urandom_range(0, 9);
      rd = (kind == 0) || (kind < 5);
      wr = (kind == 0) || (kind >= 5);
      if ($urandom_range(0, 7) == 0) fn = 3'($urandom_range(0, 7));
      else if (wr) fn = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: fn = FUNCT3_LB;
          1: fn = FUNCT3_LH;
          2: fn = FUNCT3_LW;
          3: fn = FUNCT3_LBU;
          default: fn = FUNCT3_LHU;
        endcase
      end
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 63));
      sd = $urandom;
      hold = ($urandom_range(0, 7) == 0);
      do_req(d, rd, wr, a, sd, fn, hold);
    end

    repeat (10) @(posedge clk);
    #1;
    chk(eq0.size() == 0 && eq1.size() == 0, "pending_responses", 0,
        32'(eq0.size() + eq1.size()), 32'd0);
    chk(rq0.size() + rq1.size() + wq0.size() + wq1.size() == 0, "pending_strobes", 0,
        32'(rq0.size() + rq1.size() + wq0.size() + wq1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
